// File: rtl/wb_burst_splitter_if.sv
// Wishbone bundle for wb_burst_splitter: burst master side
// toward the cache, classic single-beat side toward the slave.
interface wb_burst_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BL_W   = 10
);
    localparam int SEL_W = DATA_W / 8;

    logic              m_cyc_i;
    logic              m_stb_i;
    logic              m_we_i;
    logic [ADDR_W-1:0] m_adr_i;
    logic [BL_W-1:0]   m_bl_i;
    logic              m_bry_i;
    logic [DATA_W-1:0] m_dat_i;
    logic [SEL_W-1:0]  m_sel_i;
    logic              m_ack_o;
    logic [DATA_W-1:0] m_dat_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [SEL_W-1:0]  s_sel_o;
    logic [DATA_W-1:0] s_dat_o;
    logic              s_ack_i;
    logic [DATA_W-1:0] s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i,
        input  m_bl_i, m_bry_i, m_dat_i, m_sel_i,
        input  s_ack_i, s_dat_i,
        output m_ack_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o,
        output s_adr_o, s_sel_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i,
        output m_bl_i, m_bry_i, m_dat_i, m_sel_i,
        output s_ack_i, s_dat_i,
        input  m_ack_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o,
        input  s_adr_o, s_sel_o, s_dat_o
    );
endinterface

// File: rtl/wb_burst_splitter.sv
// Splits burst Wishbone requests into classic single-beat
// cycles; reads are buffered in a small FIFO against bry.
module wb_burst_splitter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BL_W       = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rstn,
    wb_burst_splitter_if.slave bus,
    output logic               busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, ABORT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] start_adr, beat_adr;
    logic [BL_W-1:0]   beats, issue_cnt;
    logic              we_q, pend, pend_n;
    logic              accept, inc, push, pop, flush;
    logic              all_issued, last_wr, rd_ack;
    logic              fifo_free, fifo_empty, req_stb;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt;

    assign beat_adr   = start_adr
                      + ADDR_W'({issue_cnt, 2'b00});
    assign all_issued = (issue_cnt == beats);
    assign last_wr    = (issue_cnt + BL_W'(1) == beats);
    assign fifo_empty = (cnt == '0);
    assign fifo_free  = (cnt < CW'(FIFO_DEPTH));
    assign rd_ack     = !fifo_empty && bus.m_bry_i;
    assign req_stb    = !all_issued && fifo_free;
    assign busy_o     = (state != IDLE);
    assign bus.m_dat_o = fifo_empty ? '0 : mem[rd_ptr];

    always_comb begin
        state_n     = state;
        pend_n      = pend;
        accept      = 1'b0;
        inc         = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_sel_o = '0;
        bus.s_dat_o = '0;
        bus.m_ack_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    accept  = 1'b1;
                    state_n = bus.m_we_i ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                bus.s_cyc_o = !all_issued;
                bus.s_stb_o = req_stb;
                bus.s_adr_o = beat_adr;
                bus.s_sel_o = '1;
                if (!bus.m_cyc_i) begin
                    flush   = 1'b1;
                    pend_n  = req_stb;
                    state_n = ABORT;
                end else begin
                    bus.m_ack_o = rd_ack;
                    pop         = rd_ack;
                    if (req_stb) begin
                        state_n = RD_WAIT;
                    end else if (all_issued &&
                                 (fifo_empty ||
                                  (rd_ack && cnt == CW'(1)))) begin
                        state_n = IDLE;
                    end
                end
            end
            RD_WAIT: begin
                bus.s_cyc_o = 1'b1;
                bus.s_stb_o = 1'b1;
                bus.s_adr_o = beat_adr;
                bus.s_sel_o = '1;
                if (!bus.m_cyc_i) begin
                    flush   = 1'b1;
                    pend_n  = !bus.s_ack_i;
                    state_n = ABORT;
                end else begin
                    bus.m_ack_o = rd_ack;
                    pop         = rd_ack;
                    push        = bus.s_ack_i;
                    if (bus.s_ack_i) begin
                        inc     = 1'b1;
                        state_n = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                bus.s_cyc_o = 1'b1;
                bus.s_stb_o = 1'b1;
                bus.s_we_o  = 1'b1;
                bus.s_adr_o = beat_adr;
                bus.s_sel_o = bus.m_sel_i;
                bus.s_dat_o = bus.m_dat_i;
                if (!bus.m_cyc_i) begin
                    flush   = 1'b1;
                    pend_n  = !bus.s_ack_i;
                    state_n = ABORT;
                end else begin
                    bus.m_ack_o = bus.s_ack_i;
                    if (bus.s_ack_i) begin
                        inc = 1'b1;
                        if (last_wr) state_n = IDLE;
                    end
                end
            end
            ABORT: begin
                // Finish the beat the slave already saw, drop its data.
                flush       = 1'b1;
                bus.s_cyc_o = pend;
                bus.s_stb_o = pend;
                bus.s_we_o  = pend && we_q;
                if (pend) begin
                    bus.s_adr_o = beat_adr;
                    bus.s_sel_o = we_q ? bus.m_sel_i : '1;
                    bus.s_dat_o = we_q ? bus.m_dat_i : '0;
                end
                if (!pend || bus.s_ack_i) begin
                    pend_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            start_adr <= '0;
            beats     <= '0;
            issue_cnt <= '0;
            we_q      <= 1'b0;
            pend      <= 1'b0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            if (accept) begin
                start_adr <= bus.m_adr_i;
                beats     <= (bus.m_bl_i == '0) ?
                             BL_W'(1) : bus.m_bl_i;
                issue_cnt <= '0;
                we_q      <= bus.m_we_i;
            end else if (inc) begin
                issue_cnt <= issue_cnt + BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.s_dat_i;
    end
endmodule

// File: tb/tb_wb_burst_splitter.sv
// Bench for wb_burst_splitter: vector table, corner
// sequences and random bursts against a burst model.
module tb_wb_burst_splitter;
    logic clk;
    logic rstn;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    wb_burst_splitter_if #(
        .ADDR_W(32), .DATA_W(32), .BL_W(10)
    ) bus ();

    wb_burst_splitter #(
        .ADDR_W(32), .DATA_W(32),
        .BL_W(10), .FIFO_DEPTH(2)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus),
        .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } beat_t;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [9:0]  bl;
        int          exp_beats;
        logic [31:0] exp_last;
    } vec_t;

    beat_t       slv[$];
    logic [31:0] got[$];
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    int          m_acks, n_hold, first_sack, first_mack;
    logic        stb_hold;
    bit          timed_out;
    vec_t        tbl[6];

    function automatic logic [31:0] rd_fn(
        input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic fill_wd();
        for (int k = 0; k < 16; k++) begin
            wd[k] = $urandom;
            ws[k] = 4'($urandom_range(15));
        end
    endtask

    task automatic run_burst(input bit we,
                             input logic [31:0] adr,
                             input logic [9:0] bl,
                             input int hold,
                             input int pct,
                             input int wmax,
                             input int ab);
        int cyc, seen, cw;
        bit done;
        slv.delete();
        got.delete();
        m_acks = 0;
        n_hold = -1;
        stb_hold = 1'b0;
        first_sack = -1;
        first_mack = -1;
        timed_out = 1'b0;
        seen = 0;
        cw = $urandom_range(wmax);
        cyc = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            if (cyc > 0 && !busy) begin
                done = 1'b1;
            end else if (cyc > 300) begin
                done = 1'b1;
                timed_out = 1'b1;
            end else begin
                if (cyc == 0) begin
                    bus.m_cyc_i = 1'b1;
                    bus.m_stb_i = 1'b1;
                    bus.m_we_i  = we;
                    bus.m_adr_i = adr;
                    bus.m_bl_i  = bl;
                end else begin
                    bus.m_stb_i = 1'b0;
                end
                // Slave acks no earlier than the 2nd strobe cycle.
                if (bus.s_ack_i) begin
                    bus.s_ack_i = 1'b0;
                    seen = bus.s_stb_o ? 1 : 0;
                    cw = $urandom_range(wmax);
                end else if (bus.s_stb_o) begin
                    if (seen >= 1 + cw) begin
                        bus.s_ack_i = 1'b1;
                        bus.s_dat_i = rd_fn(bus.s_adr_o);
                    end else begin
                        seen++;
                    end
                end else begin
                    seen = 0;
                end
                bus.m_bry_i = (cyc >= hold) &&
                              ($urandom_range(99) < pct);
                bus.m_dat_i = wd[m_acks & 15];
                bus.m_sel_i = ws[m_acks & 15];
                if (ab > 0 && m_acks >= ab &&
                    bus.s_stb_o && !bus.s_ack_i)
                    bus.m_cyc_i = 1'b0;
                @(negedge clk);
                if (bus.m_ack_o) begin
                    m_acks++;
                    if (first_mack < 0) first_mack = cyc;
                    if (!we) got.push_back(bus.m_dat_o);
                end
                if (bus.s_ack_i) begin
                    if (first_sack < 0) first_sack = cyc;
                    slv.push_back('{bus.s_we_o,
                        bus.s_adr_o,
                        we ? bus.s_dat_o : bus.s_dat_i,
                        bus.s_sel_o});
                end
                if (cyc == hold) begin
                    n_hold = slv.size();
                    stb_hold = bus.s_stb_o;
                end
                cyc++;
            end
        end
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_bry_i = 1'b0;
        bus.s_ack_i = 1'b0;
        chk("timeout", 32'(timed_out), 0);
        if (timed_out) do_reset();
    endtask

    task automatic check_burst(input string nm,
                               input bit we,
                               input logic [31:0] adr,
                               input logic [9:0] bl);
        int n;
        logic [31:0] ea;
        n = (bl == 0) ? 1 : int'(bl);
        chk({nm, "_beats"}, slv.size(), n);
        chk({nm, "_macks"}, m_acks, n);
        for (int i = 0; i < n && i < slv.size(); i++) begin
            ea = adr + 32'(4 * i);
            chk({nm, "_adr"}, slv[i].adr, ea);
            chk({nm, "_we"}, 32'(slv[i].we), 32'(we));
            if (we) begin
                chk({nm, "_wdat"}, slv[i].dat, wd[i]);
                chk({nm, "_wsel"}, 32'(slv[i].sel),
                    32'(ws[i]));
            end else begin
                chk({nm, "_rsel"}, 32'(slv[i].sel), 32'hF);
                if (i < got.size())
                    chk({nm, "_rdat"}, got[i], rd_fn(ea));
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 32'h0000_1000, 10'd4, 4, 32'h0000_100C};
        tbl[1] = '{1, 32'h0000_2000, 10'd2, 2, 32'h0000_2004};
        tbl[2] = '{0, 32'h0000_3000, 10'd0, 1, 32'h0000_3000};
        tbl[3] = '{0, 32'hFFFF_FFF8, 10'd4, 4, 32'h0000_0004};
        tbl[4] = '{1, 32'hFFFF_FFFC, 10'd3, 3, 32'h0000_0004};
        tbl[5] = '{0, 32'h0000_0040, 10'd1, 1, 32'h0000_0040};

        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.m_we_i  = 1'b0;
        bus.m_adr_i = '0;
        bus.m_bl_i  = '0;
        bus.m_bry_i = 1'b0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0;
        bus.s_dat_i = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctl", {bus.s_cyc_o, bus.s_stb_o,
            bus.s_we_o, bus.m_ack_o}, 0);
        chk("rst_adr", bus.s_adr_o, 0);
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_wd();
            if (i == 1) begin
                wd[0] = 32'hA5A5_A5A5;
                ws[0] = 4'hF;
                wd[1] = 32'h5A5A_5A5A;
                ws[1] = 4'h3;
            end
            run_burst(tbl[i].we, tbl[i].adr, tbl[i].bl,
                      0, 100, 0, 0);
            chk("tbl_beats", slv.size(), tbl[i].exp_beats);
            chk("tbl_last", (slv.size() > 0) ?
                slv[slv.size() - 1].adr : 32'hDEAD_DEAD,
                tbl[i].exp_last);
            check_burst("tbl", tbl[i].we, tbl[i].adr,
                        tbl[i].bl);
            if (i == 0)
                chk("rd_lat", first_mack - first_sack, 1);
        end

        run_burst(0, 32'h0000_1100, 10'd4, 10, 100, 0, 0);
        chk("bry0_fetched", n_hold, 2);
        chk("bry0_stb", 32'(stb_hold), 0);
        check_burst("bry0", 0, 32'h0000_1100, 10'd4);

        run_burst(0, 32'h0000_7000, 10'd4, 0, 100, 0, 1);
        chk("abort_macks", m_acks, 1);
        chk("abort_beats", slv.size(), 3);
        if (slv.size() == 3)
            chk("abort_adr", slv[2].adr, 32'h0000_7008);
        chk("abort_idle", 32'(busy), 0);
        run_burst(0, 32'h0000_7800, 10'd2, 0, 100, 1, 0);
        check_burst("post_abort", 0, 32'h0000_7800, 10'd2);

        @(posedge clk); #1;
        bus.m_cyc_i = 1'b1;
        bus.m_stb_i = 1'b1;
        bus.m_we_i  = 1'b1;
        bus.m_adr_i = 32'h0000_5000;
        bus.m_bl_i  = 10'd4;
        bus.m_dat_i = 32'h1234_5678;
        bus.m_sel_i = 4'hC;
        @(posedge clk); #1;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        chk("wr_passthru", 32'(bus.m_ack_o), 1);
        @(posedge clk); #1;
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        chk("wr_beat1_adr", bus.s_adr_o, 32'h0000_5004);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ctl", {bus.s_cyc_o, bus.s_stb_o,
            bus.s_we_o, bus.m_ack_o, busy}, 0);
        chk("mid_rst_adr", bus.s_adr_o, 0);
        chk("mid_rst_dat", bus.s_dat_o, 0);
        chk("mid_rst_sel", 32'(bus.s_sel_o), 0);
        chk("mid_rst_mdat", bus.m_dat_o, 0);
        bus.m_cyc_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        run_burst(0, 32'h0000_6000, 10'd1, 0, 100, 0, 0);
        check_burst("post_rst", 0, 32'h0000_6000, 10'd1);

        for (int r = 0; r < 25; r++) begin
            bit          rwe;
            logic [31:0] radr;
            logic [9:0]  rbl;
            rwe  = 1'($urandom_range(1));
            radr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0)
                radr = 32'hFFFF_FFF0 |
                       32'($urandom_range(3) * 4);
            rbl = 10'($urandom_range(6));
            fill_wd();
            run_burst(rwe, radr, rbl, 0,
                      $urandom_range(30, 100),
                      $urandom_range(2), 0);
            check_burst("rand", rwe, radr, rbl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
